// File: rtl/prog_chain_loader.sv
// Configuration shift-chain loader: serialises CHAIN_LEN bits from a
// valid/ready word stream onto the chain head and captures the bits leaving
// the chain tail as readback words.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; chain not shifting
// LOAD   | accepting words and issuing bits until CHAIN_LEN bits are out
// FINISH | one cycle: done pulse, final readback word if one is pending
module prog_chain_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_en,
    output logic              chain_din,
    input  logic              chain_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_CW    = $clog2(CHAIN_LEN + 1);
    localparam int BUF_CW    = $clog2(WORD_W + 1);
    localparam int WRD_CW    = $clog2(NUM_WORDS + 1);
    localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
    // Left-align shift for a trailing partial readback word (0 when exact).
    localparam int RB_PAD    = (WORD_W - (CHAIN_LEN % WORD_W)) % WORD_W;

    localparam logic [BIT_CW-1:0] CHAIN_LEN_C  = BIT_CW'(CHAIN_LEN);
    localparam logic [BUF_CW-1:0] WORD_W_C     = BUF_CW'(WORD_W);
    localparam logic [BUF_CW-1:0] WORD_LAST_C  = BUF_CW'(WORD_W - 1);
    localparam logic [BUF_CW-1:0] LAST_BITS_C  = BUF_CW'(LAST_BITS);
    localparam logic [WRD_CW-1:0] NUM_WORDS_C  = WRD_CW'(NUM_WORDS);
    localparam logic [WRD_CW-1:0] LAST_WORD_C  = WRD_CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_W-1:0] buf_q;
    logic [BUF_CW-1:0] buf_cnt;
    logic [WRD_CW-1:0] words_acc;
    logic [BIT_CW-1:0] bits_sent;
    logic [WORD_W-1:0] rb_shift;
    logic [BUF_CW-1:0] rb_cnt;

    logic              issue;
    logic              last_sample;
    logic              xfer;
    logic [WORD_W-1:0] rb_next;

    // A bit leaves the buffer whenever LOAD has buffered bits.
    assign issue       = (state == S_LOAD) && (buf_cnt != '0);
    // The cycle showing the final chain_en=1; its edge ends the pass.
    assign last_sample = (state == S_LOAD) && (bits_sent == CHAIN_LEN_C);
    assign xfer        = cfg_valid && cfg_ready;
    assign rb_next     = {rb_shift[WORD_W-2:0], chain_tail};

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and decoded outputs; ready also opens while the last buffered bit leaves.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                cfg_ready = (words_acc < NUM_WORDS_C) &&
                            ((buf_cnt == '0) || ((buf_cnt == BUF_CW'(1)) && issue));
                if (last_sample) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Word buffer, bit issue and counters.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            buf_q     <= '0;
            buf_cnt   <= '0;
            words_acc <= '0;
            bits_sent <= '0;
            chain_en  <= 1'b0;
            chain_din <= 1'b0;
        end else begin
            chain_en <= issue;
            if (state == S_IDLE && start) begin
                buf_cnt   <= '0;
                words_acc <= '0;
                bits_sent <= '0;
            end
            if (issue) begin
                chain_din <= buf_q[WORD_W-1];
                bits_sent <= bits_sent + BIT_CW'(1);
            end
            if (xfer) begin
                buf_q     <= cfg_data;
                buf_cnt   <= (words_acc == LAST_WORD_C) ? LAST_BITS_C : WORD_W_C;
                words_acc <= words_acc + WRD_CW'(1);
            end else if (issue) begin
                buf_q   <= buf_q << 1;
                buf_cnt <= buf_cnt - BUF_CW'(1);
            end
        end
    end

    // Readback capture: the tail bit is taken on every edge the chain shifts.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            rb_shift <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (state == S_IDLE && start) begin
                rb_shift <= '0;
                rb_cnt   <= '0;
            end
            if (chain_en) begin
                if (rb_cnt == WORD_LAST_C) begin
                    rb_data  <= rb_next;
                    rb_valid <= 1'b1;
                    rb_shift <= '0;
                    rb_cnt   <= '0;
                end else if (last_sample) begin
                    rb_data  <= rb_next << RB_PAD;
                    rb_valid <= 1'b1;
                    rb_shift <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_shift <= rb_next;
                    rb_cnt   <= rb_cnt + BUF_CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: a 12-bit instance exercised with directed and
// random passes against a bit-level chain model, plus a 16-bit instance for
// the exact-multiple readback case.
module tb_prog_chain_loader;

    localparam int CL  = 12;
    localparam int WW  = 8;
    localparam int NW  = (CL + WW - 1) / WW;
    localparam int CL2 = 16;

    int checks   = 0;
    int failures = 0;

    logic prog_clk = 1'b0;
    logic prog_rst;
    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    // Cycle counter used for latency and span measurements.
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Instance A (CHAIN_LEN=12).
    logic          start, cfg_valid, cfg_ready, chain_en, chain_din, chain_tail;
    logic          rb_valid, busy, done;
    logic [WW-1:0] cfg_data, rb_data;

    prog_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(prog_clk), .prog_rst(prog_rst), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .chain_en(chain_en), .chain_din(chain_din), .chain_tail(chain_tail),
        .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    // Instance B (CHAIN_LEN=16).
    logic          b_start, b_cfg_valid, b_cfg_ready, b_chain_en, b_chain_din, b_chain_tail;
    logic          b_rb_valid, b_busy, b_done;
    logic [WW-1:0] b_cfg_data, b_rb_data;

    prog_chain_loader #(.CHAIN_LEN(CL2), .WORD_W(WW)) dut_b (
        .prog_clk(prog_clk), .prog_rst(prog_rst), .start(b_start),
        .cfg_data(b_cfg_data), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .chain_en(b_chain_en), .chain_din(b_chain_din), .chain_tail(b_chain_tail),
        .rb_data(b_rb_data), .rb_valid(b_rb_valid), .busy(b_busy), .done(b_done)
    );

    // External chain models: shift on every edge where chain_en is high.
    logic [CL-1:0]  chain_q   = '1;
    logic [CL2-1:0] b_chain_q = '1;
    assign chain_tail   = chain_q[CL-1];
    assign b_chain_tail = b_chain_q[CL2-1];
    always @(posedge prog_clk) if (chain_en) chain_q <= {chain_q[CL-2:0], chain_din};
    always @(posedge prog_clk) if (b_chain_en) b_chain_q <= {b_chain_q[CL2-2:0], b_chain_din};

    // Observation of instance A (monotonic records; passes use baselines).
    int            en_cyc[$];
    logic          din_bits[$];
    logic [WW-1:0] rb_q[$];
    int            din_err = 0, done_cnt = 0, rb_done_cnt = 0;
    logic          busy_at_done = 1'b0, busy_after_done = 1'b1, prev_done = 1'b0, prev_din = 1'b0;

    always @(negedge prog_clk) begin
        if (chain_en) begin
            en_cyc.push_back(cyc);
            din_bits.push_back(chain_din);
        end else if (busy && chain_din !== prev_din) begin
            din_err++;
        end
        if (rb_valid) begin
            rb_q.push_back(rb_data);
            if (done) rb_done_cnt++;
        end
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
        if (prev_done) busy_after_done = busy;
        prev_done = done;
        prev_din  = chain_din;
    end

    // Observation of instance B.
    int            b_en_cnt = 0, b_done_cnt = 0, b_rb_done = 0, b_acc = 0, b_ready_late = 0;
    logic [WW-1:0] b_rb_q[$];

    always @(negedge prog_clk) begin
        if (b_chain_en) b_en_cnt++;
        if (b_rb_valid) begin
            b_rb_q.push_back(b_rb_data);
            if (b_done) b_rb_done++;
        end
        if (b_done) b_done_cnt++;
        if (b_cfg_ready && b_acc >= 2) b_ready_late++;
        if (b_cfg_valid && b_cfg_ready) b_acc++;
    end

    // Expected chain contents, maintained from the loading rules only.
    logic [CL-1:0] ref_chain = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rb_at(input int idx);
        if (idx < rb_q.size()) return 32'(rb_q[idx]);
        return 'x;
    endfunction

    // Present one word; first hold valid low for 'gap' cycles in which ready is high.
    task automatic send_word(input logic [WW-1:0] w, input int gap);
        int   n;
        int   g;
        logic acc;
        g = gap;
        n = 0;
        cfg_valid = 1'b0;
        while (g > 0 && n < 200) begin
            @(negedge prog_clk);
            if (cfg_ready) g--;
            @(posedge prog_clk); #1;
            n++;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge prog_clk);
            acc = cfg_ready;
            @(posedge prog_clk); #1;
            n++;
        end
        check("cfg_accept", acc, 1);
    endtask

    // One complete load pass on instance A with checks against the reference.
    task automatic run_pass(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input int g1, input bit spam);
        logic [WW-1:0] words[2];
        logic [CL-1:0] exp_chain, obs_din;
        logic [WW-1:0] exp_rb[NW];
        int            idx, n, start_cyc, en0, din0, rb0, dn0, rbd0, derr0, ne;
        words[0] = w0;
        words[1] = w1;
        for (int i = 0; i < CL; i++) exp_chain[CL-1-i] = words[i/WW][WW-1-(i%WW)];
        for (int k = 0; k < NW; k++) begin
            exp_rb[k] = '0;
            for (int j = 0; j < WW; j++) begin
                idx = k * WW + j;
                if (idx < CL) exp_rb[k][WW-1-j] = ref_chain[CL-1-idx];
            end
        end
        en0 = en_cyc.size(); din0 = din_bits.size(); rb0 = rb_q.size();
        dn0 = done_cnt; rbd0 = rb_done_cnt; derr0 = din_err;

        @(posedge prog_clk); #1;
        check("busy_idle", busy, 0);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1);
        send_word(w0, 0);
        if (spam) start = 1'b1;
        send_word(w1, g1);
        cfg_valid = 1'b0;
        start = 1'b0;
        n = 0;
        while (done_cnt == dn0 && n < 100) begin
            @(posedge prog_clk); #1;
            n++;
        end
        repeat (3) @(posedge prog_clk);
        #1;

        ne = en_cyc.size() - en0;
        check("en_count", ne, CL);
        check("first_en_latency", (ne > 0) ? en_cyc[en0] - start_cyc : -1, 3);
        check("en_span", (ne > 0) ? en_cyc[en_cyc.size()-1] - en_cyc[en0] + 1 : -1, CL + g1);
        obs_din = '0;
        for (int i = 0; i < CL && din0 + i < din_bits.size(); i++) obs_din[CL-1-i] = din_bits[din0+i];
        check("din_stream", obs_din, exp_chain);
        check("din_hold", din_err - derr0, 0);
        check("chain_contents", chain_q, exp_chain);
        check("rb_count", rb_q.size() - rb0, NW);
        for (int k = 0; k < NW; k++) check("rb_word", rb_at(rb0 + k), exp_rb[k]);
        check("rb_with_done", rb_done_cnt - rbd0, 1);
        check("done_count", done_cnt - dn0, 1);
        check("busy_at_done", busy_at_done, 1);
        check("busy_after_done", busy_after_done, 0);
        ref_chain = exp_chain;
    endtask

    initial begin
        int            n, rb0, dn0;
        logic [WW-1:0] w;
        logic [CL-1:0] exp_chain;
        logic          acc;

        prog_rst = 1'b1;
        start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        b_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("reset_state", {cfg_ready, chain_en, chain_din, rb_valid, busy, done, rb_data}, 0);
        check("reset_state_b", {b_cfg_ready, b_chain_en, b_chain_din, b_rb_valid, b_busy, b_done, b_rb_data}, 0);
        prog_rst = 1'b0;

        // Back-to-back A5, A3 from the all-ones chain.
        rb0 = rb_q.size();
        run_pass(8'hA5, 8'hA3, 0, 1'b0);
        check("pass1_chain", chain_q, 12'hA5A);
        check("pass1_rb0", rb_at(rb0), 8'hFF);
        check("pass1_rb1", rb_at(rb0 + 1), 8'hF0);

        // Zeros: reads back the previous contents, left-aligned tail.
        rb0 = rb_q.size();
        run_pass(8'h00, 8'h00, 0, 1'b0);
        check("pass2_chain", chain_q, 12'h000);
        check("pass2_rb0", rb_at(rb0), 8'hA5);
        check("pass2_rb1", rb_at(rb0 + 1), 8'hA0);

        // Three-cycle valid gap between words.
        run_pass(8'hA5, 8'hA3, 3, 1'b0);
        check("gap_chain", chain_q, 12'hA5A);

        // start held high during LOAD must not restart.
        run_pass(8'h5C, 8'h3E, 1, 1'b1);

        // Reset after five bits have been shifted.
        dn0 = done_cnt;
        rb0 = rb_q.size();
        n   = en_cyc.size();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        w = 8'($urandom);
        send_word(w, 0);
        cfg_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge prog_clk); #1;
            acc = (en_cyc.size() - n >= 5);
        end
        check("rst_bits_before", en_cyc.size() - n, 5);
        prog_rst = 1'b1;
        @(negedge prog_clk); #1;
        check("rst_outputs", {cfg_ready, chain_en, chain_din, rb_valid, busy, done, rb_data}, 0);
        prog_rst = 1'b0;
        repeat (6) @(posedge prog_clk);
        #1;
        check("rst_no_done", done_cnt - dn0, 0);
        check("rst_no_rb", rb_q.size() - rb0, 0);
        for (int i = 0; i < CL; i++) exp_chain[i] = (i >= 5) ? ref_chain[i-5] : w[i+3];
        check("rst_chain", chain_q, exp_chain);
        ref_chain = exp_chain;

        // Random passes after the aborted one.
        for (int r = 0; r < 8; r++)
            run_pass(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Instance B: exact multiple of the word width.
        @(posedge prog_clk); #1;
        b_start = 1'b1;
        @(posedge prog_clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_cfg_data  = (k == 0) ? 8'h3C : 8'h96;
            b_cfg_valid = 1'b1;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 100) begin
                @(negedge prog_clk);
                acc = b_cfg_ready;
                @(posedge prog_clk); #1;
                n++;
            end
            check("b_cfg_accept", acc, 1);
        end
        n = 0;
        while (b_done_cnt == 0 && n < 100) begin
            @(posedge prog_clk); #1;
            n++;
        end
        b_cfg_valid = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("b_en_count", b_en_cnt, CL2);
        check("b_chain", b_chain_q, 16'h3C96);
        check("b_rb_count", b_rb_q.size(), 2);
        check("b_rb0", (b_rb_q.size() > 0) ? 32'(b_rb_q[0]) : 'x, 8'hFF);
        check("b_rb1", (b_rb_q.size() > 1) ? 32'(b_rb_q[1]) : 'x, 8'hFF);
        check("b_rb_with_done", b_rb_done, 1);
        check("b_done_count", b_done_cnt, 1);
        check("b_ready_after_last", b_ready_late, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

endmodule
